// File: rtl/somador_serial_pkg.sv
// Shared types and constants for the serial adder/subtractor.
//   estado_t   : sequencer states
//   MODO_SOMA  : mode value for A+B
//   MODO_SUB   : mode value for A-B
//   N_PADRAO   : default operand width
package somador_serial_pkg;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        CALC   = 2'd1,
        FIM    = 2'd2
    } estado_t;

    localparam logic MODO_SOMA = 1'b0;
    localparam logic MODO_SUB  = 1'b1;

    localparam int unsigned N_PADRAO = 8;

endpackage

// File: rtl/somador_serial_if.sv
// Request/result bundle between a requester and the serial adder.
//   inicio, M, A, B          : request (driven by master)
//   ocupado, pronto, R, Tf, ovf : status and result (driven by slave)
interface somador_serial_if
    import somador_serial_pkg::*;
#(
    parameter int unsigned N = N_PADRAO
) ();

    logic         inicio;
    logic         M;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         ocupado;
    logic         pronto;
    logic [N-1:0] R;
    logic         Tf;
    logic         ovf;

    modport master (
        output inicio, M, A, B,
        input  ocupado, pronto, R, Tf, ovf
    );

    modport slave (
        input  inicio, M, A, B,
        output ocupado, pronto, R, Tf, ovf
    );

endinterface

// File: rtl/somador_subtrator.sv
// One-bit full adder/subtractor cell, purely combinational.
//   M  : mode (MODO_SOMA / MODO_SUB)
//   A,B: operand bits; Te: transport in (carry or borrow)
//   S  : sum/difference bit; Ts: transport out
module somador_subtrator
    import somador_serial_pkg::*;
(
    input  logic M,
    input  logic A,
    input  logic B,
    input  logic Te,
    output logic S,
    output logic Ts
);

    // Sum and difference share the same bit; only the transport differs.
    always_comb begin
        S = A ^ B ^ Te;
        if (M == MODO_SUB) begin
            Ts = (~A & B) | (~(A ^ B) & Te);
        end else begin
            Ts = (A & B) | ((A ^ B) & Te);
        end
    end

endmodule

// File: rtl/somador_serial.sv
// Bit-serial N-bit adder/subtractor sequencing one somador_subtrator cell,
// LSB first, with the transport held in a flop between bits.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of somador_serial_if (request in, result out)
module somador_serial
    import somador_serial_pkg::*;
#(
    parameter int unsigned N = N_PADRAO
) (
    input  logic              clk,
    input  logic              rst,
    somador_serial_if.slave   bus
);

    localparam int unsigned CW = $clog2(N);

    estado_t       estado_q, estado_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  r_q, r_d;
    logic          m_q, m_d;
    logic          t_q, t_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ocupado_q, ocupado_d;
    logic          pronto_q, pronto_d;
    logic [N-1:0]  res_q, res_d;
    logic          tf_q, tf_d;
    logic          ovf_q, ovf_d;

    logic          s_c;
    logic          ts_c;

    // Single bit cell, always looking at the current LSBs and transport.
    somador_subtrator u_celula (
        .M  (m_q),
        .A  (a_q[0]),
        .B  (b_q[0]),
        .Te (t_q),
        .S  (s_c),
        .Ts (ts_c)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q  <= OCIOSO;
            a_q       <= '0;
            b_q       <= '0;
            r_q       <= '0;
            m_q       <= 1'b0;
            t_q       <= 1'b0;
            cnt_q     <= '0;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
            res_q     <= '0;
            tf_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            a_q       <= a_d;
            b_q       <= b_d;
            r_q       <= r_d;
            m_q       <= m_d;
            t_q       <= t_d;
            cnt_q     <= cnt_d;
            ocupado_q <= ocupado_d;
            pronto_q  <= pronto_d;
            res_q     <= res_d;
            tf_q      <= tf_d;
            ovf_q     <= ovf_d;
        end
    end

    // Next-state, shifting and completion capture.
    always_comb begin
        estado_d = estado_q;
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        m_d      = m_q;
        t_d      = t_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        tf_d     = tf_q;
        ovf_d    = ovf_q;

        case (estado_q)
            OCIOSO: begin
                if (bus.inicio) begin
                    estado_d = CALC;
                    a_d      = bus.A;
                    b_d      = bus.B;
                    m_d      = bus.M;
                    t_d      = 1'b0;
                    cnt_d    = '0;
                end
            end
            CALC: begin
                t_d   = ts_c;
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                r_d   = {s_c, r_q[N-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    estado_d = FIM;
                    res_d    = {s_c, r_q[N-1:1]};
                    tf_d     = ts_c;
                    // Transport into vs. out of the sign bit disagree on overflow.
                    ovf_d    = t_q ^ ts_c;
                end
            end
            FIM: begin
                estado_d = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase

        ocupado_d = (estado_d != OCIOSO);
        pronto_d  = (estado_d == FIM);
    end

    assign bus.ocupado = ocupado_q;
    assign bus.pronto  = pronto_q;
    assign bus.R       = res_q;
    assign bus.Tf      = tf_q;
    assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_somador_serial.sv
// Self-checking bench for somador_serial (N=8): directed cases plus random
// operations checked against an integer-arithmetic reference model.
module tb_somador_serial;

    localparam int unsigned N = 8;

    logic clk = 1'b0;
    logic rst;

    somador_serial_if #(.N(N)) bus ();

    somador_serial #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {R, Tf, ovf} from plain unsigned/signed arithmetic.
    function automatic logic [9:0] modelo(input logic m, input logic [7:0] a, input logic [7:0] b);
        int ua, ub, sa, sb, us, ss;
        logic [7:0] r;
        logic tf, ov;
        ua = int'(a);
        ub = int'(b);
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        if (m == 1'b0) begin
            us = ua + ub;
            ss = sa + sb;
            tf = (us > 255);
        end else begin
            us = ua - ub;
            ss = sa - sb;
            tf = (ua < ub);
        end
        r  = 8'(us);
        ov = (ss > 127) || (ss < -128);
        return {r, tf, ov};
    endfunction

    // Starts one operation and waits (bounded) for pronto. inj_edge>0 pulses a
    // conflicting start sampled at accept-edge + inj_edge. Returns at the pronto cycle.
    task automatic do_op(input logic m, input logic [7:0] a, input logic [7:0] b,
                         input int inj_edge, output int lat, output logic [9:0] res,
                         output bit busy_ok, output bit hold_ok);
        logic [9:0] prev;
        prev       = {bus.R, bus.Tf, bus.ovf};
        bus.inicio = 1'b1;
        bus.M      = m;
        bus.A      = a;
        bus.B      = b;
        tick();
        bus.inicio = 1'b0;
        bus.M      = 1'($urandom);
        bus.A      = 8'($urandom);
        bus.B      = 8'($urandom);
        lat     = -1;
        res     = '0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            if (i == inj_edge) begin
                bus.inicio = 1'b1;
                bus.A      = 8'hFF;
                bus.B      = 8'hFF;
            end else begin
                bus.inicio = 1'b0;
            end
            tick();
            if (bus.ocupado !== 1'b1) busy_ok = 1'b0;
            if (bus.pronto === 1'b1) begin
                lat = i;
                res = {bus.R, bus.Tf, bus.ovf};
                break;
            end
            if ({bus.R, bus.Tf, bus.ovf} !== prev) hold_ok = 1'b0;
        end
        bus.inicio = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus.inicio = 1'b1;
        bus.M      = 1'b0;
        bus.A      = 8'h03;
        bus.B      = 8'h04;
        tick();
        tick();
        checks++;
        if ({bus.ocupado, bus.pronto, bus.R, bus.Tf, bus.ovf} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 000",
                     {bus.ocupado, bus.pronto, bus.R, bus.Tf, bus.ovf});
        end
        rst        = 1'b0;
        bus.inicio = 1'b0;
        tick();
        checks++;
        if (bus.ocupado !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_start: ocupado got %b expected 0", bus.ocupado);
        end
    endtask

    task automatic test_directed(input string nome, input logic m, input logic [7:0] a,
                                 input logic [7:0] b, input logic [9:0] esperado);
        int lat;
        logic [9:0] res;
        bit busy_ok, hold_ok;
        do_op(m, a, b, 0, lat, res, busy_ok, hold_ok);
        checks++;
        if (res !== esperado) begin
            failures++;
            $display("FAIL %s_result: got {R,Tf,ovf}=%h expected %h", nome, res, esperado);
        end
        checks++;
        if (lat != 8 || !busy_ok || !hold_ok) begin
            failures++;
            $display("FAIL %s_timing: latency %0d busy %0b hold %0b expected 8 1 1",
                     nome, lat, busy_ok, hold_ok);
        end
        tick();
        checks++;
        if ({bus.ocupado, bus.pronto} !== 2'b00) begin
            failures++;
            $display("FAIL %s_release: got ocupado,pronto=%b expected 00", nome,
                     {bus.ocupado, bus.pronto});
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [9:0] res;
        bit busy_ok, hold_ok;
        do_op(1'b1, 8'h80, 8'h01, 0, lat, res, busy_ok, hold_ok);
        checks++;
        if (res !== {8'h7F, 1'b0, 1'b1} || lat != 8) begin
            failures++;
            $display("FAIL b2b_first: got %h lat %0d expected %h lat 8", res, lat,
                     {8'h7F, 1'b0, 1'b1});
        end
        // Start held high through the FIM edge must be ignored there.
        bus.inicio = 1'b1;
        bus.M      = 1'b1;
        bus.A      = 8'h7F;
        bus.B      = 8'hFF;
        tick();
        checks++;
        if ({bus.ocupado, bus.pronto} !== 2'b00) begin
            failures++;
            $display("FAIL b2b_fim_ignore: got ocupado,pronto=%b expected 00",
                     {bus.ocupado, bus.pronto});
        end
        do_op(1'b1, 8'h7F, 8'hFF, 0, lat, res, busy_ok, hold_ok);
        checks++;
        if (res !== {8'h80, 1'b1, 1'b1} || lat != 8 || !hold_ok) begin
            failures++;
            $display("FAIL b2b_second: got %h lat %0d hold %0b expected %h lat 8 hold 1",
                     res, lat, hold_ok, {8'h80, 1'b1, 1'b1});
        end
        tick();
    endtask

    task automatic test_busy_isolation();
        int lat, extra;
        logic [9:0] res;
        bit busy_ok, hold_ok;
        do_op(1'b0, 8'h10, 8'h20, 3, lat, res, busy_ok, hold_ok);
        checks++;
        if (res !== {8'h30, 1'b0, 1'b0} || lat != 8 || !busy_ok) begin
            failures++;
            $display("FAIL busy_result: got %h lat %0d busy %0b expected %h lat 8 busy 1",
                     res, lat, busy_ok, {8'h30, 1'b0, 1'b0});
        end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.pronto === 1'b1 || bus.ocupado === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL busy_single_pronto: got %0d stray busy/pronto cycles expected 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        int lat, stray;
        logic [9:0] res;
        bit busy_ok, hold_ok;
        bus.inicio = 1'b1;
        bus.M      = 1'b0;
        bus.A      = 8'hA5;
        bus.B      = 8'h3C;
        tick();
        bus.inicio = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({bus.ocupado, bus.pronto, bus.R, bus.Tf, bus.ovf} !== 12'h000) begin
            failures++;
            $display("FAIL reset_mid_outputs: got %h expected 000",
                     {bus.ocupado, bus.pronto, bus.R, bus.Tf, bus.ovf});
        end
        stray = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.pronto === 1'b1 || bus.ocupado === 1'b1) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL reset_mid_discard: got %0d stray busy/pronto cycles expected 0", stray);
        end
        do_op(1'b0, 8'h01, 8'h01, 0, lat, res, busy_ok, hold_ok);
        checks++;
        if (res !== {8'h02, 1'b0, 1'b0} || lat != 8) begin
            failures++;
            $display("FAIL reset_mid_restart: got %h lat %0d expected %h lat 8", res, lat,
                     {8'h02, 1'b0, 1'b0});
        end
        tick();
    endtask

    task automatic test_random();
        int lat;
        logic [9:0] res, esperado;
        bit busy_ok, hold_ok;
        logic m;
        logic [7:0] a, b;
        for (int n = 0; n < 40; n++) begin
            m        = 1'($urandom);
            a        = 8'($urandom);
            b        = 8'($urandom);
            esperado = modelo(m, a, b);
            do_op(m, a, b, 0, lat, res, busy_ok, hold_ok);
            checks++;
            if (res !== esperado) begin
                failures++;
                $display("FAIL random_result: M=%b A=%h B=%h got %h expected %h",
                         m, a, b, res, esperado);
            end
            checks++;
            if (lat != 8 || !busy_ok || !hold_ok) begin
                failures++;
                $display("FAIL random_timing: latency %0d busy %0b hold %0b expected 8 1 1",
                         lat, busy_ok, hold_ok);
            end
            tick();
            // Occasionally idle an extra cycle so both spacings are exercised.
            if ($urandom_range(1, 0) == 1) tick();
        end
    endtask

    initial begin
        rst        = 1'b1;
        bus.inicio = 1'b0;
        bus.M      = 1'b0;
        bus.A      = '0;
        bus.B      = '0;
        test_reset();
        test_directed("add_ovf",   1'b0, 8'h3C, 8'h45, {8'h81, 1'b0, 1'b1});
        test_directed("add_carry", 1'b0, 8'hFF, 8'h01, {8'h00, 1'b1, 1'b0});
        test_directed("sub_borrow", 1'b1, 8'h05, 8'h07, {8'hFE, 1'b1, 1'b0});
        test_back_to_back();
        test_busy_isolation();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
